// File: rtl/phase_bank_loader_pkg.sv
// Shared constants and types for the transducer phase bank loader.
package phase_bank_loader_pkg;

    localparam int VAL_W = 24;

    localparam logic [7:0] OP_DIVIDE = 8'hFE;
    localparam logic [7:0] OP_COMMIT = 8'hFF;

    localparam logic [VAL_W-1:0] DIV_RESET_DEF = 24'd624;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P0,
        ST_P1,
        ST_P2,
        ST_SYNC
    } pbl_state_e;

    typedef struct packed {
        logic             en;
        logic [7:0]       sel;
        logic [VAL_W-1:0] data;
    } shadow_wr_t;

endpackage

// File: rtl/phase_bank_loader_cmd_deframer.sv
// Byte-stream deframer: opcode decode, payload assembly and idle timeout.
module phase_cmd_deframer
    import phase_bank_loader_pkg::*;
#(
    parameter int NCH     = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       sync_done,
    output shadow_wr_t wr,
    output logic       commit,
    output logic       err,
    output logic       busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0] NCH_B = 8'(NCH);

    pbl_state_e       state_q, state_d;
    logic [7:0]       op_q, op_d;
    logic [15:0]      hi_q, hi_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic             commit_q, commit_d;
    logic             err_q, err_d;
    logic             xfer;

    assign in_ready = (state_q != ST_SYNC);
    assign busy     = (state_q != ST_IDLE);
    assign xfer     = in_valid && in_ready;
    assign commit   = commit_q;
    assign err      = err_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        hi_d     = hi_q;
        idle_d   = '0;
        commit_d = 1'b0;
        err_d    = 1'b0;
        wr       = '0;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    unique case (1'b1)
                        (in_data == OP_COMMIT): begin
                            state_d  = ST_SYNC;
                            commit_d = 1'b1;
                        end
                        (in_data == OP_DIVIDE),
                        (in_data < NCH_B): begin
                            op_d    = in_data;
                            state_d = ST_P0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_P0: begin
                if (xfer) begin
                    hi_d[15:8] = in_data;
                    state_d    = ST_P1;
                end
            end
            ST_P1: begin
                if (xfer) begin
                    hi_d[7:0] = in_data;
                    state_d   = ST_P2;
                end
            end
            ST_P2: begin
                if (xfer) begin
                    wr.en   = 1'b1;
                    wr.sel  = op_q;
                    wr.data = {hi_q, in_data};
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (sync_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A byte arriving on the expiry cycle keeps the packet alive.
        if (state_q inside {ST_P0, ST_P1, ST_P2} && !xfer) begin
            if (idle_q >= CNT_LAST) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            hi_q     <= '0;
            idle_q   <= '0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            idle_q   <= idle_d;
            commit_q <= commit_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: rtl/phase_bank_loader.sv
// Shadow/active register banks for the channel dividers with atomic commit.
module phase_bank_loader
    import phase_bank_loader_pkg::*;
#(
    parameter int               NCH       = 8,
    parameter int               SYNC_LEN  = 4,
    parameter int               TIMEOUT   = 50000,
    parameter logic [VAL_W-1:0] DIV_RESET = DIV_RESET_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NCH*VAL_W-1:0] offset_flat,
    output logic [VAL_W-1:0]     divide,
    output logic                 sync_out,
    output logic                 err,
    output logic                 busy
);

    localparam int SC_W = $clog2(SYNC_LEN + 1);

    logic [NCH-1:0][VAL_W-1:0] sh_off_q, sh_off_d;
    logic [NCH-1:0][VAL_W-1:0] act_off_q, act_off_d;
    logic [VAL_W-1:0]          sh_div_q, sh_div_d;
    logic [VAL_W-1:0]          act_div_q, act_div_d;
    logic [SC_W-1:0]           sync_q, sync_d;
    logic                      rng_err_q, rng_err_d;

    shadow_wr_t wr;
    logic       commit;
    logic       df_err;
    logic       sync_done;

    phase_cmd_deframer #(
        .NCH     (NCH),
        .TIMEOUT (TIMEOUT)
    ) u_deframer (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sync_done (sync_done),
        .wr        (wr),
        .commit    (commit),
        .err       (df_err),
        .busy      (busy)
    );

    assign sync_done   = (sync_q == SC_W'(1));
    assign sync_out    = (sync_q != '0);
    assign offset_flat = act_off_q;
    assign divide      = act_div_q;
    assign err         = df_err | rng_err_q;

    always_comb begin
        sh_off_d = sh_off_q;
        sh_div_d = sh_div_q;
        if (wr.en) begin
            if (wr.sel == OP_DIVIDE) begin
                sh_div_d = wr.data;
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    if (wr.sel == 8'(k)) begin
                        sh_off_d[k] = wr.data;
                    end
                end
            end
        end
    end

    // Offsets beyond the new divide would never fire; load them as zero.
    always_comb begin
        act_off_d = act_off_q;
        act_div_d = act_div_q;
        rng_err_d = 1'b0;
        sync_d    = (sync_q != '0) ? sync_q - 1'b1 : '0;
        if (commit) begin
            act_div_d = sh_div_q;
            sync_d    = SC_W'(SYNC_LEN);
            for (int k = 0; k < NCH; k++) begin
                if (sh_off_q[k] > sh_div_q) begin
                    act_off_d[k] = '0;
                    rng_err_d    = 1'b1;
                end else begin
                    act_off_d[k] = sh_off_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_off_q  <= '0;
            act_off_q <= '0;
            sh_div_q  <= DIV_RESET;
            act_div_q <= DIV_RESET;
            sync_q    <= '0;
            rng_err_q <= 1'b0;
        end else begin
            sh_off_q  <= sh_off_d;
            act_off_q <= act_off_d;
            sh_div_q  <= sh_div_d;
            act_div_q <= act_div_d;
            sync_q    <= sync_d;
            rng_err_q <= rng_err_d;
        end
    end

endmodule

// File: tb/tb_phase_bank_loader.sv
// Scoreboard bench for phase_bank_loader against a packet-level model.
module tb_phase_bank_loader;

    localparam int          NCH      = 8;
    localparam int          SYNC_LEN = 4;
    localparam int          TO       = 3000;
    localparam logic [23:0] DIV_RST  = 24'd624;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [7:0]           in_data = 8'h00;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [NCH*24-1:0]    offset_flat;
    logic [23:0]          divide;
    logic                 sync_out;
    logic                 err;
    logic                 busy;

    phase_bank_loader #(
        .NCH       (NCH),
        .SYNC_LEN  (SYNC_LEN),
        .TIMEOUT   (TO),
        .DIV_RESET (DIV_RST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .offset_flat (offset_flat),
        .divide      (divide),
        .sync_out    (sync_out),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                is_commit;
        logic [NCH*24-1:0] off;
        logic [23:0]       dv;
        bit                e;
    } ev_t;

    ev_t evq[$];
    int  checks = 0;
    int  errors = 0;

    logic [23:0] m_off [NCH];
    logic [23:0] m_div;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) m_off[k] = '0;
        m_div = DIV_RST;
    endtask

    task automatic push_err();
        ev_t ev;
        ev.is_commit = 1'b0;
        ev.off = '0;
        ev.dv = '0;
        ev.e = 1'b1;
        evq.push_back(ev);
    endtask

    initial begin : monitor
        logic [NCH*24-1:0] mon_off;
        logic [23:0]       mon_div;
        bit                prev_sync;
        int                sync_len;
        ev_t               ev;
        mon_off = '0;
        mon_div = DIV_RST;
        prev_sync = 1'b0;
        sync_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_off = '0;
                mon_div = DIV_RST;
                prev_sync = 1'b0;
                sync_len = 0;
                continue;
            end
            if (sync_out && !prev_sync) begin
                if (evq.size() > 0 && evq[0].is_commit) begin
                    ev = evq.pop_front();
                    mon_off = ev.off;
                    mon_div = ev.dv;
                    check("commit_err", err, ev.e);
                end else begin
                    flag("unexpected_sync");
                end
            end else if (err) begin
                if (evq.size() > 0 && !evq[0].is_commit) begin
                    ev = evq.pop_front();
                    check("err_busy", busy, 0);
                end else begin
                    flag("unexpected_err");
                end
            end
            check("offset_flat", offset_flat, mon_off);
            check("divide", divide, mon_div);
            if (sync_out) begin
                sync_len++;
                check("ready_in_sync", in_ready, 0);
            end else if (prev_sync) begin
                check("sync_len", sync_len, SYNC_LEN);
                check("ready_after_sync", in_ready, 1);
                sync_len = 0;
            end
            prev_sync = sync_out;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) flag("ready_wait_expired");
        in_data = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic send_val(input logic [23:0] v, input bit jit);
        for (int i = 2; i >= 0; i--) begin
            if (jit) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(v[8*i +: 8]);
        end
    endtask

    task automatic wr_ch(input int ch, input logic [23:0] v, input bit jit);
        send_byte(8'(ch));
        send_val(v, jit);
        m_off[ch] = v;
    endtask

    task automatic wr_div(input logic [23:0] v, input bit jit);
        send_byte(8'hFE);
        send_val(v, jit);
        m_div = v;
    endtask

    task automatic do_commit();
        ev_t ev;
        ev.is_commit = 1'b1;
        ev.e = 1'b0;
        ev.dv = m_div;
        ev.off = '0;
        for (int k = 0; k < NCH; k++) begin
            if (m_off[k] > m_div) ev.e = 1'b1;
            else ev.off[24*k +: 24] = m_off[k];
        end
        send_byte(8'hFF);
        evq.push_back(ev);
        @(negedge clk);
        check("commit_sync_lat0", sync_out, 0);
        check("commit_ready0", in_ready, 0);
        @(negedge clk);
        check("commit_sync_lat1", sync_out, 1);
    endtask

    task automatic bad_op(input logic [7:0] b);
        send_byte(b);
        push_err();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_offset", offset_flat, 0);
        check("rst_divide", divide, DIV_RST);
        check("rst_sync", sync_out, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b0;
        model_reset();
        evq.delete();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int op;
        logic [23:0] v;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("init_offset", offset_flat, 0);
        check("init_divide", divide, DIV_RST);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", in_ready, 1);
            check("idle_sync", sync_out, 0);
            check("idle_busy", busy, 0);
        end

        wr_ch(3, 24'd300, 1'b0);
        check("shadow_no_disturb", offset_flat[95:72], 0);
        do_commit();
        do_commit();

        wr_div(24'd999, 1'b0);
        wr_ch(0, 24'd1000, 1'b0);
        do_commit();

        send_byte(8'h02);
        send_byte(8'h00);
        repeat (TO) @(negedge clk);
        check("to_busy_before", busy, 1);
        check("to_err_before", err, 0);
        push_err();
        @(negedge clk);
        check("to_busy_after", busy, 0);
        wr_ch(2, 24'd5, 1'b0);
        do_commit();

        send_byte(8'h02);
        send_byte(8'h00);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h00);
        check("expiry_edge_busy", busy, 1);
        send_byte(8'h0B);
        m_off[2] = 24'd11;
        do_commit();

        bad_op(8'h80);
        wr_ch(7, 24'd123, 1'b0);
        do_commit();

        send_byte(8'h05);
        send_byte(8'h00);
        do_reset();
        wr_ch(5, 24'd9, 1'b0);
        do_commit();
        do_reset();

        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 6);
            v = ($urandom_range(0, 7) == 0) ? 24'($urandom)
                                            : 24'($urandom_range(0, 2000));
            if (op <= 3) wr_ch($urandom_range(0, NCH - 1), v, 1'b1);
            else if (op == 4) wr_div(v, 1'b1);
            else if (op == 5) do_commit();
            else bad_op(8'($urandom_range(NCH, 253)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        do_commit();
        repeat (SYNC_LEN + 4) @(negedge clk);
        check("queue_empty", evq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
